// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_hazard_ctrl                                                 |
// | Purpose : Stage enable/flush sequencer for a 5-stage RV32 pipeline:        |
// |           load-use bubbles, taken-branch flushes, data-memory wait stalls. |
// | Option  : PIPE_HAZARD_CTRL_PERF_EN enables stall/flush counters.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             mem_acc,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int         TCNT_W   = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ERR  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [TCNT_W-1:0] r_tcnt;
    logic [TCNT_W-1:0] w_tcnt_nxt;
    logic              w_load_use;
    logic              w_mem_stall;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    assign w_load_use = ex_is_load && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_mem_stall = mem_acc && !dmem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    always_comb begin
        dmem_req    = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        err         = 1'b0;
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;

        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (r_state)
                c_ST_RUN, c_ST_WAIT: begin
                    dmem_req = mem_acc;
                    if (w_mem_stall) begin
                        // Everything upstream of MEM holds; WB receives bubbles
                        memwb_en    = 1'b1;
                        memwb_flush = 1'b1;
                        w_state_nxt = c_ST_WAIT;
                        if (r_state == c_ST_RUN) begin
                            w_tcnt_nxt = TCNT_W'(1);
                        end else if (r_tcnt == TCNT_W'(MEM_TIMEOUT - 1)) begin
                            w_state_nxt = c_ST_ERR;
                        end else begin
                            w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = c_ST_RUN;
                        w_tcnt_nxt  = '0;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        idex_en     = 1'b1;
                        if (ex_br_taken) begin
                            pc_en      = 1'b1;
                            ifid_en    = 1'b1;
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (w_load_use) begin
                            idex_flush = 1'b1;
                        end else begin
                            pc_en   = 1'b1;
                            ifid_en = 1'b1;
                        end
                    end
                end
                default: begin
                    err         = 1'b1;
                    w_state_nxt = c_ST_ERR;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_in_err;

    assign w_in_err = (r_state != c_ST_RUN) && (r_state != c_ST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && !w_in_err && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((ifid_flush || idex_flush) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipe_hazard_ctrl                                              |
// | Purpose : Directed self-checking bench for pipe_hazard_ctrl.               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 16;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam int c_PERF = 1;
`else
    localparam int c_PERF = 0;
`endif

    // {dmem_req, pc, ifid, idex, exmem, memwb en, ifid/idex/memwb flush, err}
    localparam logic [9:0] c_V_RST  = 10'b0_00000_111_0;
    localparam logic [9:0] c_V_NORM = 10'b0_11111_000_0;
    localparam logic [9:0] c_V_ZW   = 10'b1_11111_000_0;
    localparam logic [9:0] c_V_LU   = 10'b0_00111_010_0;
    localparam logic [9:0] c_V_BR   = 10'b0_11111_110_0;
    localparam logic [9:0] c_V_BRQ  = 10'b1_11111_110_0;
    localparam logic [9:0] c_V_WAIT = 10'b1_00001_001_0;
    localparam logic [9:0] c_V_ERR  = 10'b0_00000_000_1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;
    logic             mem_acc, dmem_ack;
    logic             dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, memwb_flush, err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .mem_acc(mem_acc), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1ns after a rising edge; outputs checked 1ns later, then advance
    task automatic cycle(input string tag, input logic [9:0] exp);
        #1;
        chk(tag, {22'd0, dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, memwb_flush, err}, {22'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    task automatic set_ex(input logic ld, input logic [4:0] rd, input logic br);
        ex_is_load = ld; ex_rd = rd; ex_br_taken = br;
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        chk({tag, "_stall"}, {16'd0, stall_cnt}, c_PERF * s);
        chk({tag, "_flush"}, {16'd0, flush_cnt}, c_PERF * f);
    endtask

    initial begin
        rst = 1'b1; mem_acc = 1'b0; dmem_ack = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0);
        set_ex(1'b0, 5'd0, 1'b0);
        cycle("rst0", c_V_RST);
        cycle("rst1", c_V_RST);
        rst = 1'b0;
        chk_cnt("cnt_after_rst", 0, 0);
        cycle("norm0", c_V_NORM);

        // load x5 in EX, ID add x6,x5,x1: one bubble then flow
        set_ex(1'b1, 5'd5, 1'b0); set_id(5'd5, 1'b1, 5'd1, 1'b1);
        cycle("lu_rs1", c_V_LU);
        set_ex(1'b0, 5'd0, 1'b0);
        cycle("lu_rs1_after", c_V_NORM);
        set_ex(1'b1, 5'd7, 1'b0); set_id(5'd3, 1'b1, 5'd7, 1'b1);
        cycle("lu_rs2", c_V_LU);
        set_id(5'd3, 1'b1, 5'd7, 1'b0);
        cycle("lu_rs2_unused", c_V_NORM);
        set_ex(1'b1, 5'd0, 1'b0); set_id(5'd0, 1'b1, 5'd0, 1'b1);
        cycle("lu_x0", c_V_NORM);

        // branch overrides a simultaneous load-use
        set_ex(1'b1, 5'd5, 1'b1); set_id(5'd5, 1'b1, 5'd1, 1'b1);
        cycle("br_over_lu", c_V_BR);
        set_ex(1'b0, 5'd0, 1'b0);
        cycle("br_after", c_V_NORM);
        chk_cnt("cnt_a", 2, 3);

        // memory waits 3 cycles; a branch arriving meanwhile is held until the ack
        mem_acc = 1'b1;
        cycle("mw_c0", c_V_WAIT);
        ex_br_taken = 1'b1;
        cycle("mw_c1_br_held", c_V_WAIT);
        cycle("mw_c2", c_V_WAIT);
        dmem_ack = 1'b1;
        cycle("mw_ack_br", c_V_BRQ);
        mem_acc = 1'b0; dmem_ack = 1'b0; ex_br_taken = 1'b0;
        cycle("mw_after", c_V_NORM);
        chk_cnt("cnt_b", 5, 4);

        // zero-wait access
        mem_acc = 1'b1; dmem_ack = 1'b1;
        cycle("zero_wait", c_V_ZW);
        dmem_ack = 1'b0;

        // ack on the last cycle before timeout releases normally
        for (int i = 0; i < 15; i++) cycle("mw_long", c_V_WAIT);
        dmem_ack = 1'b1;
        cycle("ack_at_limit", c_V_ZW);
        mem_acc = 1'b0; dmem_ack = 1'b0;
        cycle("limit_after", c_V_NORM);
        chk_cnt("cnt_c", 20, 4);

        // no ack: 16 cycles of request, then ERR which ignores ack
        mem_acc = 1'b1;
        for (int i = 0; i < 16; i++) cycle("to_wait", c_V_WAIT);
        cycle("to_err", c_V_ERR);
        dmem_ack = 1'b1;
        cycle("err_ack_ignored", c_V_ERR);
        chk_cnt("cnt_err", 36, 4);
        rst = 1'b1; dmem_ack = 1'b0;
        cycle("err_rst", c_V_RST);
        rst = 1'b0; mem_acc = 1'b0;
        chk_cnt("cnt_err_rst", 0, 0);
        cycle("err_rst_run", c_V_NORM);

        // reset in the middle of a wait abandons the request
        mem_acc = 1'b1;
        cycle("rw_c0", c_V_WAIT);
        cycle("rw_c1", c_V_WAIT);
        rst = 1'b1;
        cycle("rw_rst", c_V_RST);
        rst = 1'b0; mem_acc = 1'b0;
        chk_cnt("cnt_rw", 0, 0);
        cycle("rw_run", c_V_NORM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
